// File: rtl/ringosc_meas_ctrl.sv
// ringosc_meas_ctrl: sequences a bank of ring oscillators, one at a time.
// Each oscillator is enabled, allowed to settle, and then its rising edges are
// counted over a gate window measured in clk cycles. Each result is returned
// over a valid/ready port.
// Build option: define RINGOSC_MEAS_IRQ_EN to add a sticky scan-complete irq
// output and an irq_clr input.
//
// state     | meaning
// S_IDLE    | no scan running; waiting for start
// S_SELECT  | find the next unmasked oscillator, or end the scan
// S_SETTLE  | selected oscillator enabled; waiting SETTLE cycles
// S_MEASURE | counting synchronized rising edges over the gate window
// S_REPORT  | result held on res_* until the handshake

module ringosc_meas_ctrl #(
    parameter int NUM_RO = 4,
    parameter int CNT_W  = 16,
    parameter int GATE_W = 16,
    parameter int SETTLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [NUM_RO-1:0] ro_mask,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_id,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_ovf
`ifdef RINGOSC_MEAS_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam int IDX_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_RO-1:0]  mask_q, mask_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [NUM_RO-1:0]  ro_en_q, ro_en_d;
    logic               res_valid_q, res_valid_d;
    logic [3:0]         res_id_q, res_id_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               res_ovf_q, res_ovf_d;
    logic [NUM_RO-1:0]  sync1_q, sync2_q, sync3_q;

    logic [NUM_RO-1:0]  edges;
    logic               edge_sel;
    logic               nxt_found;
    logic [IDX_W-1:0]   nxt_idx;
    logic [NUM_RO-1:0]  sel_onehot;
    logic [GATE_W-1:0]  gate_m1;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_nxt;

    // Two-flop synchronizer per oscillator, plus a third flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // ro_en_q is one-hot on the oscillator under test, so it selects the edge to count.
    assign edges    = sync2_q & ~sync3_q;
    assign edge_sel = |(edges & ro_en_q);
    assign gate_m1  = (gate_q == '0) ? '0 : gate_q - 1'b1;

    // Find the lowest unmasked index at or above idx, and its one-hot enable.
    always_comb begin
        nxt_found  = 1'b0;
        nxt_idx    = '0;
        sel_onehot = '0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (!mask_q[i] && (IDX_W'(i) >= idx_q)) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_RO; i++) begin
            sel_onehot[i] = (IDX_W'(i) == nxt_idx);
        end
    end

    // Saturating edge counter; ovf flags an edge lost because the count is at its maximum.
    always_comb begin
        cnt_nxt = cnt_q;
        ovf_nxt = ovf_q;
        if (edge_sel) begin
            if (&cnt_q) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end
    end

    // Next-state and datapath logic for the scan sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        gate_d      = gate_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        ro_en_d     = ro_en_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        res_ovf_d   = res_ovf_q;
        if (abort) begin
            state_d     = S_IDLE;
            ro_en_d     = '0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !(&ro_mask)) begin
                        mask_d  = ro_mask;
                        gate_d  = gate_len;
                        idx_d   = '0;
                        state_d = S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!nxt_found) begin
                        // Continuous mode reloads the configuration and starts over.
                        if (cont && !(&ro_mask)) begin
                            mask_d  = ro_mask;
                            gate_d  = gate_len;
                            idx_d   = '0;
                            state_d = S_SELECT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d   = nxt_idx;
                        ro_en_d = sel_onehot;
                        tmr_d   = TMR_W'(SETTLE - 1);
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr_q == '0) begin
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        tmr_d   = TMR_W'(gate_m1);
                        state_d = S_MEASURE;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_MEASURE: begin
                    cnt_d = cnt_nxt;
                    ovf_d = ovf_nxt;
                    if (tmr_q == '0) begin
                        // Any edge seen in the final gate cycle is included via cnt_nxt.
                        ro_en_d     = '0;
                        res_valid_d = 1'b1;
                        res_id_d    = idx_q[3:0];
                        res_count_d = cnt_nxt;
                        res_ovf_d   = ovf_nxt;
                        state_d     = S_REPORT;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        idx_d       = idx_q + 1'b1;
                        state_d     = S_SELECT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ro_en_d = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            gate_q      <= '0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            ro_en_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_count_q <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            gate_q      <= gate_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            ro_en_q     <= ro_en_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign ro_en     = ro_en_q;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;
    assign res_ovf   = res_ovf_q;

`ifdef RINGOSC_MEAS_IRQ_EN
    logic irq_q;
    logic scan_done;

    assign scan_done = (state_q == S_SELECT) && !nxt_found && !abort;

    // Sticky scan-complete flag; a completion in the same cycle as irq_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= scan_done | (irq_q & ~irq_clr);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Bench for ringosc_meas_ctrl: a default instance and a CNT_W=4 instance share all inputs.
// Expected results are queued per scan and checked by a handshake monitor.
`timescale 1ns/1ps
module tb_ringosc_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        abort = 1'b0;
    logic        res_ready = 1'b1;
    logic [3:0]  ro_mask = 4'h0;
    logic [15:0] gate_len = 16'd100;
    logic [3:0]  ro_in = 4'h0;

    logic [3:0]  ro_en, s_ro_en;
    logic        busy, s_busy, res_valid, s_res_valid, res_ovf, s_res_ovf;
    logic [3:0]  res_id, s_res_id;
    logic [15:0] res_count;
    logic [3:0]  s_res_count;
`ifdef RINGOSC_MEAS_IRQ_EN
    logic        irq, s_irq;
    logic        irq_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int id;
        int lo;
        int hi;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    int       ro_mode = 0;
    int       ro_cnt[4];
    logic [3:0] forbid_en = 4'h0;
    bit       onehot_bad = 1'b0;
    bit       idle_en_bad = 1'b0;
    bit       forbid_seen = 1'b0;
    int       n_hs = 0;

    ringosc_meas_ctrl #(.NUM_RO(4), .CNT_W(16), .GATE_W(16), .SETTLE(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .ro_mask(ro_mask), .gate_len(gate_len), .ro_in(ro_in), .ro_en(ro_en),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_count(res_count), .res_ovf(res_ovf)
`ifdef RINGOSC_MEAS_IRQ_EN
        , .irq(irq), .irq_clr(irq_clr)
`endif
    );

    ringosc_meas_ctrl #(.NUM_RO(4), .CNT_W(4), .GATE_W(16), .SETTLE(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .ro_mask(ro_mask), .gate_len(gate_len), .ro_in(ro_in), .ro_en(s_ro_en),
        .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready), .res_id(s_res_id),
        .res_count(s_res_count), .res_ovf(s_res_ovf)
`ifdef RINGOSC_MEAS_IRQ_EN
        , .irq(s_irq), .irq_clr(irq_clr)
`endif
    );

    always #5 clk = ~clk;

    // Oscillator model: mode 0 period 8+2k, mode 1 period 4, otherwise constant high.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ro_mode == 0 || ro_mode == 1) begin
                    ro_cnt[k]++;
                    if (ro_cnt[k] >= ((ro_mode == 0) ? (4 + k) : 2)) begin
                        ro_cnt[k] = 0;
                        ro_in[k] = ~ro_in[k];
                    end
                end else begin
                    ro_in[k] = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: invariants every cycle, results compared on each handshake.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if ($countones(ro_en) > 1) onehot_bad = 1'b1;
            if (!busy && ro_en != 4'h0) idle_en_bad = 1'b1;
            if ((ro_en & forbid_en) != 4'h0) forbid_seen = 1'b1;
            if (res_valid && res_ready) begin
                n_hs++;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got id=%0d count=%0d, required no result", res_id, res_count);
                end else begin
                    mon_e = sb_q.pop_front();
                    checks++;
                    if (res_id !== 4'(mon_e.id)) begin
                        errors++;
                        $display("FAIL sb_id got=%0d exp=%0d", res_id, mon_e.id);
                    end
                    checks++;
                    if (int'(res_count) < mon_e.lo || int'(res_count) > mon_e.hi) begin
                        errors++;
                        $display("FAIL sb_count id=%0d got=%0d exp=%0d..%0d", mon_e.id, res_count, mon_e.lo, mon_e.hi);
                    end
                    checks++;
                    if (res_ovf !== 1'b0) begin
                        errors++;
                        $display("FAIL sb_ovf id=%0d got=%0b exp=0", mon_e.id, res_ovf);
                    end
                    checks++;
                    if (s_res_valid !== 1'b1 || s_res_id !== 4'(mon_e.id)) begin
                        errors++;
                        $display("FAIL sb_sat_id got valid=%0b id=%0d exp valid=1 id=%0d", s_res_valid, s_res_id, mon_e.id);
                    end
                    checks++;
                    if (int'(s_res_count) < ((mon_e.lo > 15) ? 15 : mon_e.lo) ||
                        int'(s_res_count) > ((mon_e.hi > 15) ? 15 : mon_e.hi)) begin
                        errors++;
                        $display("FAIL sb_sat_count id=%0d got=%0d exp=%0d..%0d", mon_e.id, s_res_count,
                                 (mon_e.lo > 15) ? 15 : mon_e.lo, (mon_e.hi > 15) ? 15 : mon_e.hi);
                    end
                    checks++;
                    if (s_res_ovf !== ((mon_e.lo > 15) ? 1'b1 : 1'b0)) begin
                        errors++;
                        $display("FAIL sb_sat_ovf id=%0d got=%0b exp=%0b", mon_e.id, s_res_ovf, (mon_e.lo > 15));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int id, input int gate);
        exp_t e;
        int p;
        p = 8 + 2 * id;
        e.id = id;
        e.lo = gate / p;
        e.hi = (gate + p - 1) / p;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ro_en, busy, res_valid, res_id, res_count, res_ovf} !== 27'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", {ro_en, busy, res_valid, res_id, res_count, res_ovf});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ro_en !== 4'h0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%0b ro_en=%h valid=%0b exp 0 0 0", busy, ro_en, res_valid);
        end
        checks++;
        if (res_id !== 4'd0 || res_count !== 16'd0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_result got id=%0d count=%0d ovf=%0b exp 0", res_id, res_count, res_ovf);
        end
    endtask

    task automatic test_basic();
        int lat;
        int base;
        base = n_hs;
        ro_mode = 0;
        ro_mask = 4'h0;
        gate_len = 16'd100;
        for (int k = 0; k < 4; k++) push_exp(k, 100);
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!res_valid && lat < 500);
        checks++;
        if (lat != 118) begin
            errors++;
            $display("FAIL basic_latency got=%0d exp=118", lat);
        end
        for (int c = 0; c < 1000 && ro_en != 4'b0010; c++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_drop got busy=%0b sat_busy=%0b exp 0", busy, s_busy);
        end
        checks++;
        if (n_hs - base != 4 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL basic_results got handshakes=%0d pending=%0d exp 4 0", n_hs - base, sb_q.size());
        end
        checks++;
        if (onehot_bad || idle_en_bad) begin
            errors++;
            $display("FAIL basic_ro_en got onehot_bad=%0b idle_en_bad=%0b exp 0 0", onehot_bad, idle_en_bad);
        end
    endtask

    task automatic test_mask_backpressure();
        logic [3:0]  h_id;
        logic [15:0] h_cnt;
        logic        h_ovf;
        bit          stall_bad;
        stall_bad = 1'b0;
        ro_mask = 4'b1010;
        forbid_en = 4'b1010;
        forbid_seen = 1'b0;
        res_ready = 1'b0;
        push_exp(0, 100);
        push_exp(2, 100);
        pulse_start();
        ro_mask = 4'b0000;
        for (int c = 0; c < 500 && !res_valid; c++) @(negedge clk);
        h_id = res_id;
        h_cnt = res_count;
        h_ovf = res_ovf;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!res_valid || res_id !== h_id || res_count !== h_cnt || res_ovf !== h_ovf) stall_bad = 1'b1;
        end
        checks++;
        if (stall_bad || h_id !== 4'd0) begin
            errors++;
            $display("FAIL mask_stall got unstable=%0b id=%0d exp 0 0", stall_bad, h_id);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
        checks++;
        if (forbid_seen || sb_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL mask_skip got masked_en=%0b pending=%0d busy=%0b exp 0 0 0", forbid_seen, sb_q.size(), busy);
        end
        forbid_en = 4'h0;
    endtask

    task automatic test_saturation();
        exp_t e;
        int lat;
        ro_mode = 1;
        ro_mask = 4'b1110;
        gate_len = 16'd200;
        e.id = 0; e.lo = 50; e.hi = 50;
        sb_q.push_back(e);
        pulse_start();
        for (int c = 0; c < 1000 && busy; c++) @(negedge clk);
        ro_mode = 2;
        gate_len = 16'd0;
        repeat (5) @(negedge clk);
        e.id = 0; e.lo = 0; e.hi = 0;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!res_valid && lat < 200);
        checks++;
        if (lat != 19) begin
            errors++;
            $display("FAIL sat_gate0_latency got=%0d exp=19", lat);
        end
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL sat_done got pending=%0d busy=%0b exp 0 0", sb_q.size(), busy);
        end
        ro_mode = 0;
        ro_mask = 4'h0;
    endtask

    task automatic test_cont_abort();
        int base;
        base = n_hs;
        gate_len = 16'd20;
        cont = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) push_exp(k, 20);
        pulse_start();
        for (int c = 0; c < 2000 && n_hs < base + 5; c++) @(negedge clk);
        cont = 1'b0;
        for (int c = 0; c < 2000 && busy; c++) @(negedge clk);
        checks++;
        if (n_hs - base != 8 || sb_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL cont_repeat got handshakes=%0d pending=%0d busy=%0b exp 8 0 0", n_hs - base, sb_q.size(), busy);
        end
        gate_len = 16'd100;
        push_exp(0, 100);
        push_exp(1, 100);
        pulse_start();
        for (int c = 0; c < 1000 && ro_en != 4'b0100; c++) @(negedge clk);
        repeat (26) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ro_en !== 4'h0 || s_ro_en !== 4'h0 || res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_next got ro_en=%h sat_ro_en=%h valid=%0b busy=%0b exp 0 0 0 0", ro_en, s_ro_en, res_valid, busy);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard got pending=%0d busy=%0b exp 0 0", sb_q.size(), busy);
        end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_start got busy=%0b exp 0", busy);
        end
    endtask

    task automatic test_async_reset();
        bit busy_seen;
        ro_mask = 4'h0;
        gate_len = 16'd100;
        pulse_start();
        for (int c = 0; c < 50 && ro_en == 4'h0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ro_en !== 4'h0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_ctrl got ro_en=%h busy=%0b valid=%0b exp 0 0 0", ro_en, busy, res_valid);
        end
        checks++;
        if (res_id !== 4'd0 || res_count !== 16'd0 || res_ovf !== 1'b0) begin
            errors++;
            $display("FAIL areset_result got id=%0d count=%0d ovf=%0b exp 0 0 0", res_id, res_count, res_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL areset_idle got busy=%0b valid=%0b pending=%0d exp 0 0 0", busy, res_valid, sb_q.size());
        end
        ro_mask = 4'hF;
        busy_seen = 1'b0;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            if (busy || ro_en != 4'h0) busy_seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (busy_seen) begin
            errors++;
            $display("FAIL all_masked got busy_or_en=1 exp 0");
        end
        ro_mask = 4'h0;
    endtask

`ifdef RINGOSC_MEAS_IRQ_EN
    task automatic test_irq();
        bit got_hs;
        got_hs = 1'b0;
        ro_mask = 4'b1110;
        gate_len = 16'd10;
        @(negedge clk);
        irq_clr = 1'b1;
        push_exp(0, 10);
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                got_hs = 1'b1;
                break;
            end
        end
        @(negedge clk);
        @(negedge clk);
        irq_clr = 1'b0;
        checks++;
        if (!got_hs || irq !== 1'b1 || s_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins got hs=%0b irq=%0b sat_irq=%0b exp 1 1 1", got_hs, irq, s_irq);
        end
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%0b exp=0", irq);
        end
        push_exp(0, 10);
        pulse_start();
        for (int c = 0; c < 200 && busy; c++) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_scan_done got=%0b exp=1", irq);
        end
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        pulse_start();
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (irq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL irq_abort got irq=%0b busy=%0b exp 0 0", irq, busy);
        end
        ro_mask = 4'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mask_backpressure();
        test_saturation();
        test_cont_abort();
        test_async_reset();
`ifdef RINGOSC_MEAS_IRQ_EN
        test_irq();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got pending=%0d exp 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
